// File: rtl/forwarding_hazard_unit.sv
// -----------------------------------------------------------------------------
// forwarding_hazard_unit
//   EX-stage operand-forwarding control and load-use hazard detection for the
//   RV32IC pipeline. Keeps shadow copies of the register fields of the
//   instructions in ID/EX, EX/MEM and MEM/WB. It produces the forwardA/forwardB
//   mux selects, the register-file write-bypass flags, and a stall/bubble
//   request for load-use hazards.
//
//   Optional feature macro: HAZARD_PERF_CNT_EN
//     When defined, the stall_count and fwd_count performance counter outputs
//     are added. Both counters wrap at 2^32 and are cleared by reset.
// -----------------------------------------------------------------------------
module forwarding_hazard_unit #(
   parameter int REG_AW            = 5,
   parameter int LOAD_STALL_CYCLES = 1   // legal range 1..3
) (
   input  logic              clk,
   input  logic              rst,            // synchronous, active-low
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_reg_write,
   input  logic              id_mem_read,
   input  logic              flush,
   output logic [1:0]        forwardA,
   output logic [1:0]        forwardB,
   output logic              stall,
   output logic              wb_bypass_rs1,
   output logic              wb_bypass_rs2
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0]       stall_count,
   output logic [31:0]       fwd_count
`endif
);

   // ID/EX needs the source registers for forwarding and mem_read for hazard
   // detection. Later stages only need their destination state, so the
   // source and load fields are dropped once an instruction leaves ID/EX.
   typedef struct packed {
      logic [REG_AW-1:0] rs1;
      logic [REG_AW-1:0] rs2;
      logic [REG_AW-1:0] rd;
      logic              reg_write;
      logic              mem_read;
   } idex_t;

   typedef struct packed {
      logic [REG_AW-1:0] rd;
      logic              reg_write;
   } dst_t;

   typedef enum logic {
      IDLE,
      HOLD
   } state_t;

   localparam logic [1:0] HOLD_LOAD = 2'(LOAD_STALL_CYCLES - 1);

   idex_t  idex, idex_next;
   dst_t   exmem, memwb;
   state_t state, state_next;
   logic [1:0] cnt, cnt_next;
   logic       hazard;

   // Forward select for one EX source operand. EX/MEM has priority over
   // MEM/WB because it holds the younger result. Writes to x0 never forward.
   function automatic logic [1:0] fwd_sel(input dst_t              ex,
                                          input dst_t              wb,
                                          input logic [REG_AW-1:0] rs);
      logic [1:0] sel;
      sel = 2'b00;
      if (ex.reg_write && (ex.rd != '0) && (ex.rd == rs))
         sel = 2'b10;
      else if (wb.reg_write && (wb.rd != '0) && (wb.rd == rs))
         sel = 2'b01;
      return sel;
   endfunction

   assign forwardA = fwd_sel(exmem, memwb, idex.rs1);
   assign forwardB = fwd_sel(exmem, memwb, idex.rs2);

   // The register file is written in WB while ID reads it. These flags tell
   // the decode stage to take the writeback value instead of the stale value.
   assign wb_bypass_rs1 = memwb.reg_write && (memwb.rd != '0) && (memwb.rd == id_rs1);
   assign wb_bypass_rs2 = memwb.reg_write && (memwb.rd != '0) && (memwb.rd == id_rs2);

   // A load in EX whose destination is read by the instruction in ID.
   assign hazard = id_valid && idex.mem_read && (idex.rd != '0) &&
                   ((idex.rd == id_rs1) || (idex.rd == id_rs2));

   // Select the next ID/EX contents: a bubble on stall or flush, otherwise the decode fields.
   always_comb begin
      // NOTE: every combinational output is given a default first, so that no
      // path through the block leaves it unassigned and no latch is inferred.
      idex_next = '0;
      if (!(stall || flush)) begin
         idex_next.rs1       = id_rs1;
         idex_next.rs2       = id_rs2;
         idex_next.rd        = id_rd;
         idex_next.reg_write = id_reg_write && id_valid;
         idex_next.mem_read  = id_mem_read && id_valid;
      end
   end

   // Shadow pipeline registers. EX/MEM and MEM/WB advance every cycle, even during a stall.
   always_ff @(posedge clk) begin
      if (!rst) begin
         idex  <= '0;
         exmem <= '0;
         memwb <= '0;
      end else begin
         // NOTE: non-blocking assignments let each stage capture the value its
         // predecessor held before this edge, so the three stages shift together.
         idex            <= idex_next;
         exmem.rd        <= idex.rd;
         exmem.reg_write <= idex.reg_write;
         memwb           <= exmem;
      end
   end

   // Stall FSM state and hold counter.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
         cnt   <= 2'd0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // Stall FSM next-state logic. A hazard stalls for one cycle in IDLE, and
   // for longer settings HOLD covers the remaining cycles.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      stall      = 1'b0;
      unique case (state)
         IDLE: begin
            if (hazard) begin
               stall = 1'b1;
               if (LOAD_STALL_CYCLES > 1) begin
                  cnt_next   = HOLD_LOAD;
                  state_next = HOLD;
               end
            end
         end
         HOLD: begin
            stall    = 1'b1;
            cnt_next = cnt - 2'd1;
            // A taken branch discards the stalled instruction, so there is no
            // reason to keep holding.
            if (flush || (cnt == 2'd1)) begin
               cnt_next   = 2'd0;
               state_next = IDLE;
            end
         end
      endcase
   end

`ifdef HAZARD_PERF_CNT_EN
   // Performance counters: count stall cycles and cycles with any active forward.
   always_ff @(posedge clk) begin
      if (!rst) begin
         stall_count <= 32'd0;
         fwd_count   <= 32'd0;
      end else begin
         if (stall)
            stall_count <= stall_count + 32'd1;
         if ((forwardA != 2'b00) || (forwardB != 2'b00))
            fwd_count <= fwd_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// -----------------------------------------------------------------------------
// tb_forwarding_hazard_unit
//   Drives two instances, with LOAD_STALL_CYCLES set to 1 and to 3, from the
//   same stimulus. A behavioural model records what was issued into EX each
//   cycle, plus the remaining stall cycles. One compare process checks every
//   output of both instances on every falling edge. Directed sequences add
//   hand-computed literal checks that pin the model.
// -----------------------------------------------------------------------------
module tb_forwarding_hazard_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, id_valid, id_reg_write, id_mem_read, flush;
   logic [4:0] id_rs1, id_rs2, id_rd;

   logic [1:0] fa1, fb1, fa3, fb3;
   logic       st1, st3, b11, b21, b13, b23;
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] sc1, fc1, sc3, fc3;
`endif

   forwarding_hazard_unit #(.REG_AW(5), .LOAD_STALL_CYCLES(1)) u1 (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
      .flush(flush), .forwardA(fa1), .forwardB(fb1), .stall(st1),
      .wb_bypass_rs1(b11), .wb_bypass_rs2(b21)
`ifdef HAZARD_PERF_CNT_EN
      , .stall_count(sc1), .fwd_count(fc1)
`endif
   );

   forwarding_hazard_unit #(.REG_AW(5), .LOAD_STALL_CYCLES(3)) u3 (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
      .flush(flush), .forwardA(fa3), .forwardB(fb3), .stall(st3),
      .wb_bypass_rs1(b13), .wb_bypass_rs2(b23)
`ifdef HAZARD_PERF_CNT_EN
      , .stall_count(sc3), .fwd_count(fc3)
`endif
   );

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------- model
   // For each instance k (0: one-cycle stall, 1: three-cycle stall):
   // issued[k][d] is the instruction that entered EX d cycles ago (d=0 is the
   // instruction in EX now). left[k] is the number of stall cycles still owed.
   typedef struct packed {
      logic [4:0] rs1, rs2, rd;
      logic       wr, ld;
   } instr_t;

   instr_t issued [2][3];
   int     left   [2];
   bit     chk_en = 1'b0;

   function automatic int lsc(input int k);
      return (k == 0) ? 1 : 3;
   endfunction

   // Take the youngest older writer of rs that is still in flight. Distance 1
   // selects the ALU result and distance 2 selects the writeback value.
   function automatic logic [1:0] m_fwd(input int k, input logic [4:0] rs);
      for (int d = 1; d <= 2; d++)
         if (issued[k][d].wr && issued[k][d].rd != 0 && issued[k][d].rd == rs)
            return (d == 1) ? 2'b10 : 2'b01;
      return 2'b00;
   endfunction

   function automatic logic m_hazard(input int k);
      return id_valid && issued[k][0].ld && issued[k][0].rd != 0 &&
             (issued[k][0].rd == id_rs1 || issued[k][0].rd == id_rs2);
   endfunction

   function automatic logic m_stall(input int k);
      return (left[k] > 0) || m_hazard(k);
   endfunction

   function automatic logic m_byp(input int k, input logic [4:0] rs);
      return issued[k][2].wr && issued[k][2].rd != 0 && issued[k][2].rd == rs;
   endfunction

   task automatic model_step();
      logic stl, hz;
      for (int k = 0; k < 2; k++) begin
         if (!rst) begin
            for (int d = 0; d < 3; d++) issued[k][d] = '0;
            left[k] = 0;
         end else begin
            hz  = m_hazard(k);
            stl = m_stall(k);
            issued[k][2] = issued[k][1];
            issued[k][1] = issued[k][0];
            issued[k][0] = (stl || flush) ? instr_t'('0) :
                           {id_rs1, id_rs2, id_rd, id_reg_write & id_valid, id_mem_read & id_valid};
            if (left[k] > 0)
               left[k] = flush ? 0 : left[k] - 1;
            else if (hz)
               left[k] = lsc(k) - 1;
         end
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   // Compare process: check every output of both instances against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         check("u1_forwardA", fa1, m_fwd(0, issued[0][0].rs1));
         check("u1_forwardB", fb1, m_fwd(0, issued[0][0].rs2));
         check("u1_stall",    st1, m_stall(0));
         check("u1_byp_rs1",  b11, m_byp(0, id_rs1));
         check("u1_byp_rs2",  b21, m_byp(0, id_rs2));
         check("u3_forwardA", fa3, m_fwd(1, issued[1][0].rs1));
         check("u3_forwardB", fb3, m_fwd(1, issued[1][0].rs2));
         check("u3_stall",    st3, m_stall(1));
         check("u3_byp_rs1",  b13, m_byp(1, id_rs1));
         check("u3_byp_rs2",  b23, m_byp(1, id_rs2));
      end
   end

   // -------------------------------------------------------------- stimulus
   // Apply one decode-stage instruction for a full cycle. The task returns
   // just after the falling edge, while those inputs are still applied.
   task automatic drive(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] d, input logic w, input logic l, input logic f);
      @(posedge clk);
      #2;
      id_valid = v; id_rs1 = r1; id_rs2 = r2; id_rd = d;
      id_reg_write = w; id_mem_read = l; flush = f;
      @(negedge clk);
      #1;
   endtask

   task automatic nop(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst = 1'b0; id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
      id_reg_write = 1'b0; id_mem_read = 1'b0; flush = 1'b0;
      repeat (2) @(posedge clk);
      #1 chk_en = 1'b1;
      @(negedge clk); #1;
      check("rst_u1_fwdA", fa1, 0); check("rst_u1_fwdB", fb1, 0);
      check("rst_u1_stall", st1, 0); check("rst_u1_b1", b11, 0); check("rst_u1_b2", b21, 0);
      check("rst_u3_fwdA", fa3, 0); check("rst_u3_stall", st3, 0);
      rst = 1'b1;

      // Back-to-back ALU: add x5 then add x6,x5,x7
      drive(1, 5'd1, 5'd2, 5'd5, 1, 0, 0);
      drive(1, 5'd5, 5'd7, 5'd6, 1, 0, 0);
      nop(1);
      check("b2b_fwdA", fa1, 2'b10); check("b2b_fwdB", fb1, 2'b00);
      check("b2b_stall", st1, 0);    check("b2b_u3_fwdA", fa3, 2'b10);
      nop(3);

      // Distance-2 dependency through rs2, then a decode read of x5 during its writeback
      drive(1, 5'd1, 5'd2, 5'd5, 1, 0, 0);
      nop(1);
      drive(1, 5'd3, 5'd5, 5'd10, 1, 0, 0);
      drive(1, 5'd5, 5'd0, 5'd0, 0, 0, 0);
      check("d2_fwdB", fb1, 2'b01); check("d2_fwdA", fa1, 2'b00);
      check("d2_byp_rs1", b11, 1);  check("d2_byp_rs2", b21, 0);
      nop(3);

      // Two writers of x5: EX/MEM wins
      drive(1, 5'd1, 5'd2, 5'd5, 1, 0, 0);
      drive(1, 5'd3, 5'd4, 5'd5, 1, 0, 0);
      drive(1, 5'd0, 5'd5, 5'd12, 1, 0, 0);
      nop(1);
      check("prio_fwdB", fb1, 2'b10); check("prio_fwdA", fa1, 2'b00);
      nop(3);

      // Load-use, one-cycle stall: lw x8 then add x9,x8,x1
      drive(1, 5'd2, 5'd0, 5'd8, 1, 1, 0);
      drive(1, 5'd8, 5'd1, 5'd9, 1, 0, 0);
      check("lu1_stall", st1, 1); check("lu1_u3_stall", st3, 1);
      drive(1, 5'd8, 5'd1, 5'd9, 1, 0, 0);
      check("lu1_stall_end", st1, 0);
      nop(1);
      check("lu1_fwdA", fa1, 2'b01); check("lu1_fwdB", fb1, 2'b00);
      nop(4);

      // Load-use, three-cycle stall: the load retires before the add reaches EX
      drive(1, 5'd2, 5'd0, 5'd8, 1, 1, 0);
      drive(1, 5'd8, 5'd1, 5'd9, 1, 0, 0);
      check("lu3_stall_c1", st3, 1);
      drive(1, 5'd8, 5'd1, 5'd9, 1, 0, 0);
      check("lu3_stall_c2", st3, 1);
      drive(1, 5'd8, 5'd1, 5'd9, 1, 0, 0);
      check("lu3_stall_c3", st3, 1); check("lu3_byp_rs1", b13, 1);
      drive(1, 5'd8, 5'd1, 5'd9, 1, 0, 0);
      check("lu3_stall_end", st3, 0);
      nop(1);
      check("lu3_fwdA", fa3, 2'b00);
      nop(4);

      // x0 writer, including a load to x0: no forward, no stall, no bypass
      drive(1, 5'd1, 5'd2, 5'd0, 1, 1, 0);
      drive(1, 5'd0, 5'd0, 5'd3, 1, 0, 0);
      check("x0_stall_u1", st1, 0); check("x0_stall_u3", st3, 0);
      drive(1, 5'd0, 5'd0, 5'd0, 0, 0, 0);
      check("x0_fwdA", fa1, 0); check("x0_fwdB", fb1, 0);
      drive(1, 5'd0, 5'd0, 5'd0, 0, 0, 0);
      check("x0_byp_rs1", b11, 0); check("x0_byp_rs2", b21, 0);
      nop(3);

      // Flush while in HOLD
      drive(1, 5'd2, 5'd0, 5'd8, 1, 1, 0);
      drive(1, 5'd8, 5'd0, 5'd9, 1, 0, 0);
      check("fh_stall_c1", st3, 1);
      drive(1, 5'd8, 5'd0, 5'd9, 1, 0, 1);
      check("fh_stall_flush", st3, 1);
      drive(1, 5'd8, 5'd0, 5'd11, 1, 0, 0);
      check("fh_stall_after", st3, 0); check("fh_fwdA", fa3, 0);
      check("fh_fwdB", fb3, 0);        check("fh_byp_rs1", b13, 1);
      nop(1);
      check("fh_fwdA_next", fa3, 0);
      nop(4);

      // Flush squashes a writer entering ID/EX
      drive(1, 5'd1, 5'd2, 5'd5, 1, 0, 1);
      drive(1, 5'd5, 5'd0, 5'd13, 1, 0, 0);
      nop(1);
      check("fsq_fwdA", fa1, 0);
      nop(3);

      // Reset for one edge with writers of x5 and x6 in flight
      drive(1, 5'd1, 5'd2, 5'd5, 1, 0, 0);
      drive(1, 5'd5, 5'd0, 5'd6, 1, 0, 0);
      rst = 1'b0;
      drive(1, 5'd5, 5'd6, 5'd7, 1, 0, 0);
      check("mr_fwdA", fa1, 0); check("mr_fwdB", fb1, 0); check("mr_stall", st1, 0);
      check("mr_byp1", b11, 0); check("mr_byp2", b21, 0);
      rst = 1'b1;
      nop(1);
      check("mr_rd_fwdA", fa1, 0); check("mr_rd_fwdB", fb1, 0);
      nop(2);

      // Reset while the three-cycle instance is in HOLD
      drive(1, 5'd2, 5'd0, 5'd8, 1, 1, 0);
      drive(1, 5'd8, 5'd0, 5'd9, 1, 0, 0);
      check("rs_stall_c1", st3, 1);
      drive(1, 5'd8, 5'd0, 5'd9, 1, 0, 0);
      check("rs_stall_hold", st3, 1);
      rst = 1'b0;
      drive(1, 5'd8, 5'd0, 5'd9, 1, 0, 0);
      check("rs_stall_after", st3, 0); check("rs_u1_stall", st1, 0);
      rst = 1'b1;
      nop(3);

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
